// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline: datapath width, ALU command codes
// and NZCV flag bit positions.
package arm_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage.
// Produces the result and the NZCV that an S-instruction would commit.
module alu
  import arm_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [3:0]       execCmd,
  input  logic [3:0]       statusIn,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       statusOut
);

  logic [WIDTH-1:0] addA;
  logic [WIDTH-1:0] addB;
  logic             carryIn;
  logic [WIDTH:0]   sum;
  logic             isArith;
  logic             isLogic;
  logic             overflow;

  // Subtraction is folded into the adder as val1 + ~val2 + cin so C is "not borrow".
  always_comb begin
    addA    = val1;
    addB    = val2;
    carryIn = 1'b0;
    isArith = 1'b0;
    case (execCmd)
      EXE_ADD: isArith = 1'b1;
      EXE_ADC: begin isArith = 1'b1; carryIn = statusIn[FLAG_C]; end
      EXE_SUB: begin isArith = 1'b1; addB = ~val2; carryIn = 1'b1; end
      EXE_SBC: begin isArith = 1'b1; addB = ~val2; carryIn = statusIn[FLAG_C]; end
      default: ;
    endcase
  end

  assign sum      = {1'b0, addA} + {1'b0, addB} + {{WIDTH{1'b0}}, carryIn};
  assign overflow = (addA[WIDTH-1] == addB[WIDTH-1]) && (sum[WIDTH-1] != addA[WIDTH-1]);

  always_comb begin
    result  = '0;
    isLogic = 1'b1;
    case (execCmd)
      EXE_MOV: result = val2;
      EXE_MVN: result = ~val2;
      EXE_AND: result = val1 & val2;
      EXE_ORR: result = val1 | val2;
      EXE_EOR: result = val1 ^ val2;
      EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: begin
        result  = sum[WIDTH-1:0];
        isLogic = 1'b0;
      end
      default: isLogic = 1'b0;
    endcase
  end

  // Logic ops only refresh N/Z; unknown commands leave every flag alone.
  always_comb begin
    statusOut = statusIn;
    if (isArith || isLogic) begin
      statusOut[FLAG_N] = result[WIDTH-1];
      statusOut[FLAG_Z] = (result == '0);
    end
    if (isArith) begin
      statusOut[FLAG_C] = sum[WIDTH];
      statusOut[FLAG_V] = overflow;
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, branch target, architectural NZCV register and the
// EX/MEM pipeline register.
module exe_stage
  import arm_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             validIn,
  input  logic [3:0]       execCmd,
  input  logic             sUpdate,
  input  logic             bIn,
  input  logic             wbEnIn,
  input  logic             memRIn,
  input  logic             memWIn,
  input  logic [3:0]       destIn,
  input  logic [WIDTH-1:0] pcIn,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [WIDTH-1:0] valRm,
  input  logic [23:0]      imm24,
  output logic [3:0]       statusReg,
  output logic             branchTaken,
  output logic [WIDTH-1:0] branchAddr,
  output logic [WIDTH-1:0] aluResOut,
  output logic [WIDTH-1:0] valRmOut,
  output logic [3:0]       destOut,
  output logic             wbEnOut,
  output logic             memROut,
  output logic             memWOut,
  output logic             validOut
);

  logic [3:0]       status_q;
  logic [3:0]       status_d;
  logic [WIDTH-1:0] aluResult;
  logic [WIDTH-1:0] aluRes_q;
  logic [WIDTH-1:0] valRm_q;
  logic [3:0]       dest_q;
  logic             wbEn_q;
  logic             memR_q;
  logic             memW_q;
  logic             valid_q;

  alu #(.WIDTH(WIDTH)) uAlu (
    .val1      (val1),
    .val2      (val2),
    .execCmd   (execCmd),
    .statusIn  (status_q),
    .result    (aluResult),
    .statusOut (status_d)
  );

  assign branchTaken = validIn & bIn & ~freeze;
  assign branchAddr  = pcIn + {{(WIDTH-26){imm24[23]}}, imm24, 2'b00};

  // Flush does not gate the flag write; only freeze and invalid slots do.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= 4'b0000;
    end else if (validIn && sUpdate && !freeze) begin
      status_q <= status_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aluRes_q <= '0;
      valRm_q  <= '0;
      dest_q   <= '0;
      wbEn_q   <= 1'b0;
      memR_q   <= 1'b0;
      memW_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else if (!freeze) begin
      if (flush || !validIn) begin
        wbEn_q  <= 1'b0;
        memR_q  <= 1'b0;
        memW_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        aluRes_q <= aluResult;
        valRm_q  <= valRm;
        dest_q   <= destIn;
        wbEn_q   <= wbEnIn;
        memR_q   <= memRIn;
        memW_q   <= memWIn;
        valid_q  <= 1'b1;
      end
    end
  end

  assign statusReg = status_q;
  assign aluResOut = aluRes_q;
  assign valRmOut  = valRm_q;
  assign destOut   = dest_q;
  assign wbEnOut   = wbEn_q;
  assign memROut   = memR_q;
  assign memWOut   = memW_q;
  assign validOut  = valid_q;

endmodule
